// File: rtl/three_bit_sync_down.sv
// ---------------------------------------------------------------------------
// three_bit_sync_down
//
// 3-bit synchronous down counter with parallel load and two counting modes:
//   mode = 0 : free-running, wraps 000 -> 111 and flags the wrap on tc
//   mode = 1 : one-shot, stops at 000 in HALT and raises done
//
// Ports
//   clk      in   1  clock; all state changes on the rising edge
//   reset    in   1  synchronous active-low reset
//   enable   in   1  count enable (decrement when high)
//   load     in   1  parallel-load strobe; wins over enable
//   LoadVal  in   3  value loaded into Count when load is high
//   mode     in   1  0 = wrap, 1 = one-shot
//   Count    out  3  registered counter value
//   CountBar out  3  bitwise complement of Count
//   tc       out  1  combinational borrow for cascading
//   done     out  1  registered one-shot completion flag
// ---------------------------------------------------------------------------
module three_bit_sync_down (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [2:0] LoadVal,
  input  logic       mode,
  output logic [2:0] Count,
  output logic [2:0] CountBar,
  output logic       tc,
  output logic       done
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_count;
  logic [2:0] w_nextCount;
  logic       r_done;
  logic       w_nextDone;
  logic       w_countZero;

  assign w_countZero = (r_count == 3'b000);

  // State register: reset returns every piece of state together so that
  // a reset in the middle of a count never leaves a partial update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_count <= 3'b000;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_done  <= w_nextDone;
    end
  end

  // Next-state logic. Load beats enable; HALT ignores enable and mode and
  // can only be left through load (or reset). In one-shot mode the step
  // that lands on 000 also enters HALT, so done rises on the same edge
  // that Count reaches zero.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextDone  = r_done;
    if (load) begin
      w_nextState = RUN;
      w_nextCount = LoadVal;
      w_nextDone  = 1'b0;
    end else if (enable && (r_state == RUN)) begin
      if (w_countZero) begin
        if (mode) begin
          // Loaded with 000 in one-shot: nothing left to count, just stop.
          w_nextState = HALT;
          w_nextDone  = 1'b1;
        end else begin
          w_nextCount = 3'b111;
        end
      end else if (mode && (r_count == 3'b001)) begin
        w_nextState = HALT;
        w_nextCount = 3'b000;
        w_nextDone  = 1'b1;
      end else begin
        w_nextCount = r_count - 3'd1;
      end
    end
  end

  // Outputs. CountBar comes straight off the count register so it cannot
  // drift from Count. tc is gated with RUN: in HALT Count sits at 000 but
  // no wrap can follow, so no borrow must be signalled.
  always_comb begin
    Count    = r_count;
    CountBar = ~r_count;
    done     = r_done;
    tc       = enable && w_countZero && !mode && !load && (r_state == RUN);
  end

endmodule

// File: tb/tb_three_bit_sync_down.sv
// ---------------------------------------------------------------------------
// tb_three_bit_sync_down
//
// Directed bench for three_bit_sync_down. Each task drives one scenario
// and compares the outputs against hand-computed values. Inputs change
// 1 ns after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_three_bit_sync_down;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [2:0] LoadVal;
  logic       mode;
  logic [2:0] Count;
  logic [2:0] CountBar;
  logic       tc;
  logic       done;

  int checks;
  int errors;

  three_bit_sync_down dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .LoadVal  (LoadVal),
    .mode     (mode),
    .Count    (Count),
    .CountBar (CountBar),
    .tc       (tc),
    .done     (done)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge, landing 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; load = 1'b1; LoadVal = 3'b101; mode = 1'b0;
    tick();
    tick();
    checks++;
    if (Count !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_count got %b want 000", Count);
    end
    checks++;
    if (CountBar !== 3'b111) begin
      errors++; $display("[TB] FAIL reset_countbar got %b want 111", CountBar);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done got %b want 0", done);
    end
    load = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_tc_disabled got %b want 0", tc);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_tc_enabled got %b want 1", tc);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] expSeq [9];
    expSeq = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011,
               3'b010, 3'b001, 3'b000, 3'b111};
    reset = 1'b1; mode = 1'b0; enable = 1'b1; load = 1'b0;
    // Counter starts at 000 out of reset, so tc is high before the first edge.
    for (int i = 0; i < 9; i++) begin
      logic expTc;
      expTc = (i == 0) || (i == 8);
      checks++;
      if (tc !== expTc) begin
        errors++; $display("[TB] FAIL wrap_tc step %0d got %b want %b", i, tc, expTc);
      end
      tick();
      checks++;
      if (Count !== expSeq[i]) begin
        errors++; $display("[TB] FAIL wrap_count step %0d got %b want %b", i, Count, expSeq[i]);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [2:0] expSeq [6];
    logic       expDone [6];
    expSeq  = '{3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    expDone = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    load = 1'b1; LoadVal = 3'b011; mode = 1'b1; enable = 1'b1;
    tick();
    checks++;
    if (Count !== 3'b011 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL oneshot_load got %b/%b want 011/0", Count, done);
    end
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (Count !== expSeq[i] || done !== expDone[i]) begin
        errors++;
        $display("[TB] FAIL oneshot_step %0d got %b/%b want %b/%b",
                 i, Count, done, expSeq[i], expDone[i]);
      end
      checks++;
      if (tc !== 1'b0) begin
        errors++; $display("[TB] FAIL oneshot_tc step %0d got %b want 0", i, tc);
      end
    end
    // In HALT, switching to wrap mode must neither restart nor raise tc.
    mode = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_tc got %b want 0", tc);
    end
    tick();
    checks++;
    if (Count !== 3'b000 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL halt_hold got %b/%b want 000/1", Count, done);
    end
  endtask

  task automatic test_reload_halt();
    mode = 1'b1;
    load = 1'b1; LoadVal = 3'b101; enable = 1'b1;
    tick();
    checks++;
    if (Count !== 3'b101 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reload_load got %b/%b want 101/0", Count, done);
    end
    load = 1'b0; LoadVal = 3'b010;
    tick();
    checks++;
    if (Count !== 3'b100) begin
      errors++; $display("[TB] FAIL reload_dec got %b want 100", Count);
    end
  endtask

  task automatic test_priority();
    mode = 1'b0;
    load = 1'b1; LoadVal = 3'b010; enable = 1'b0;
    tick();
    load = 1'b1; LoadVal = 3'b110; enable = 1'b1;
    tick();
    checks++;
    if (Count !== 3'b110) begin
      errors++; $display("[TB] FAIL prio_load_over_enable got %b want 110", Count);
    end
    load = 1'b1; LoadVal = 3'b000;
    tick();
    // Count is 000, mode 0, enable 1, but load high must suppress tc.
    checks++;
    if (tc !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_tc_load got %b want 0", tc);
    end
    load = 1'b1; LoadVal = 3'b111;
    tick();
    reset = 1'b0; load = 1'b1; LoadVal = 3'b101;
    tick();
    checks++;
    if (Count !== 3'b000) begin
      errors++; $display("[TB] FAIL prio_reset_over_load got %b want 000", Count);
    end
    reset = 1'b1; load = 1'b0;
  endtask

  task automatic test_hold();
    load = 1'b1; LoadVal = 3'b100; enable = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // LoadVal wiggles while load is low and must be ignored.
      LoadVal = 3'(i);
      tick();
      checks++;
      if (Count !== 3'b100 || CountBar !== 3'b011 || tc !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold step %0d got %b/%b/%b want 100/011/0",
                 i, Count, CountBar, tc);
      end
    end
  endtask

  task automatic test_mode_change();
    load = 1'b1; LoadVal = 3'b001; enable = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (Count !== 3'b000 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL mode_wrap_dec got %b/%b want 000/0", Count, done);
    end
    // Switch to one-shot while sitting at 000: next enabled edge halts.
    mode = 1'b1;
    tick();
    checks++;
    if (Count !== 3'b000 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL mode_switch_halt got %b/%b want 000/1", Count, done);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; LoadVal = 3'b100; enable = 1'b1; mode = 1'b0;
    tick();
    load = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (Count !== 3'b000 || CountBar !== 3'b111 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_run got %b/%b/%b want 000/111/0", Count, CountBar, done);
    end
    reset = 1'b1; load = 1'b1; LoadVal = 3'b001; mode = 1'b1;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_halt_entry got %b want 1", done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (Count !== 3'b000 || CountBar !== 3'b111 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_halt got %b/%b/%b want 000/111/0", Count, CountBar, done);
    end
    // Reset must put the FSM back in RUN: a wrap-mode count resumes.
    reset = 1'b1; mode = 1'b0;
    tick();
    checks++;
    if (Count !== 3'b111) begin
      errors++; $display("[TB] FAIL reset_run_state got %b want 111", Count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    #1;
    test_reset();
    test_wrap();
    test_one_shot();
    test_reload_halt();
    test_priority();
    test_hold();
    test_mode_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
